// File: rtl/rf_alu_pkg.sv
// Shared opcode and state encodings for the register-file execute controller.
// Imported by alu_core and rf_alu_seq.
package rf_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rf_alu_seq_alu_core.sv
// Purely combinational ALU: y is the W-bit result, c the carry/borrow/shifted-out bit.
// Kept separate from the controller so the arithmetic can be exercised on its own.
module alu_core
    import rf_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] y,
    output logic         c
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        // Bit W of the widened difference is the borrow (set iff a < b unsigned).
        diff = {1'b0, a} - {1'b0, b};
        y    = '0;
        c    = 1'b0;
        case (op)
            OP_ADD:         {c, y} = sum;
            OP_SUB, OP_CMP: {c, y} = diff;
            OP_AND:         y = a & b;
            OP_OR:          y = a | b;
            OP_XOR:         y = a ^ b;
            OP_SHL: begin
                y = {a[W-2:0], 1'b0};
                c = a[W-1];
            end
            OP_SHR: begin
                y = {1'b0, a[W-1:1]};
                c = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rf_alu_seq.sv
// Multi-cycle execute controller: READ operands from the register file, EXEC one ALU op,
// WRITE the result back (skipped for CMP), then pulse done. All outputs are registered.
module rf_alu_seq
    import rf_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [3:0]   src_a,
    input  logic [3:0]   src_b,
    input  logic [3:0]   dst,
    input  logic [W-1:0] rd_data1,
    input  logic [W-1:0] rd_data2,
    output logic [3:0]   src_sel1,
    output logic [3:0]   src_sel2,
    output logic [3:0]   dest_sel,
    output logic         wrt_enable,
    output logic [W-1:0] wrt_data,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic [2:0]   state_dbg
);

    // Handshake: start is a level request looked at only in IDLE; a request seen while
    // busy is dropped. done is a one-cycle pulse; busy covers READ through DONE.

    state_t       state, state_nx;
    logic [2:0]   op_q;
    logic [3:0]   dst_q;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] alu_y;
    logic         alu_c;

    alu_core #(.W(W)) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (op_q),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  state_nx = S_EXEC;
            S_EXEC:  state_nx = (op_q == OP_CMP) ? S_DONE : S_WRITE;
            S_WRITE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes are derived from the next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_ADD;
            dst_q      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            src_sel1   <= '0;
            src_sel2   <= '0;
            dest_sel   <= '0;
            wrt_enable <= 1'b0;
            wrt_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != S_IDLE);
            done       <= (state_nx == S_DONE);
            wrt_enable <= (state_nx == S_WRITE);
            case (state)
                S_IDLE: if (start) begin
                    op_q     <= op;
                    dst_q    <= dst;
                    src_sel1 <= src_a;
                    src_sel2 <= src_b;
                end
                S_READ: begin
                    op_a <= rd_data1;
                    op_b <= rd_data2;
                end
                S_EXEC: begin
                    result <= alu_y;
                    carry  <= alu_c;
                    zero   <= (alu_y == '0);
                    if (op_q != OP_CMP) begin
                        wrt_data <= alu_y;
                        dest_sel <= dst_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_rf_alu_seq.sv
// Directed bench for rf_alu_seq with a behavioural 16x8 register file attached.
// Expected values are hand-computed constants per vector.
module tb_rf_alu_seq;

    logic       clock;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] src_a, src_b, dst;
    logic [7:0] rd_data1, rd_data2;
    logic [3:0] src_sel1, src_sel2, dest_sel;
    logic       wrt_enable;
    logic [7:0] wrt_data;
    logic       busy, done, carry, zero;
    logic [7:0] result;
    logic [2:0] state_dbg;

    logic [7:0] rf [16];

    int n_checks = 0;
    int n_pass   = 0;

    int         wr_cnt, wr_cyc, done_cyc, stray;
    logic [7:0] wr_dat;
    logic [3:0] wr_dst;

    rf_alu_seq #(.W(8)) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .dst        (dst),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .src_sel1   (src_sel1),
        .src_sel2   (src_sel2),
        .dest_sel   (dest_sel),
        .wrt_enable (wrt_enable),
        .wrt_data   (wrt_data),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry      (carry),
        .zero       (zero),
        .state_dbg  (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural register file
    assign rd_data1 = rf[src_sel1];
    assign rd_data2 = rf[src_sel2];
    always @(posedge clock) if (wrt_enable) rf[dest_sel] <= wrt_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver: one start pulse, then watch cycles 1..12 for write and done strobes
    task automatic exec_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input bit pulse_again);
        wr_cnt   = 0;
        wr_cyc   = -1;
        done_cyc = -1;
        @(negedge clock);
        op = o; src_a = a; src_b = b; dst = d; start = 1'b1;
        for (int cyc = 1; cyc <= 12 && done_cyc < 0; cyc++) begin
            @(negedge clock);
            start = pulse_again && (cyc == 2);
            // scramble the request fields to prove they were latched
            op = ~o; src_a = ~a; src_b = ~b; dst = ~d;
            check("busy_during_op", busy, 1);
            if (wrt_enable) begin
                wr_cnt++;
                wr_cyc = cyc;
                wr_dat = wrt_data;
                wr_dst = dest_sel;
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        check("done_seen", done_cyc > 0, 1);
    endtask

    // scoreboard for one finished instruction
    task automatic expect_op(input string t, input logic [7:0] r, input logic c,
                             input logic z, input bit wr, input logic [3:0] d);
        check({t, "_result"}, result, r);
        check({t, "_carry"}, carry, c);
        check({t, "_zero"}, zero, z);
        if (wr) begin
            check({t, "_wr_cnt"}, wr_cnt, 1);
            check({t, "_wr_cycle"}, wr_cyc, 3);
            check({t, "_wr_dest"}, wr_dst, d);
            check({t, "_wr_data"}, wr_dat, r);
            check({t, "_done_cycle"}, done_cyc, 4);
            check({t, "_rf_dst"}, rf[d], r);
        end else begin
            check({t, "_wr_cnt"}, wr_cnt, 0);
            check({t, "_done_cycle"}, done_cyc, 3);
        end
        @(negedge clock);
        check({t, "_idle_busy"}, busy, 0);
        check({t, "_idle_done"}, done, 0);
        check({t, "_idle_state"}, state_dbg, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rst = 1'b1; start = 1'b1; op = 3'b000; src_a = 4'd9; src_b = 4'd9; dst = 4'd9;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wen", wrt_enable, 0);
        check("rst_wdata", wrt_data, 0);
        check("rst_sel1", src_sel1, 0);
        check("rst_sel2", src_sel2, 0);
        check("rst_dsel", dest_sel, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry, zero}, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clock);
        check("idle_no_start", busy, 0);

        // ADD 5 + 3 -> R3
        rf[1] = 8'h05; rf[2] = 8'h03;
        exec_op(3'b000, 4'd1, 4'd2, 4'd3, 1'b0);
        expect_op("add", 8'h08, 1'b0, 1'b0, 1'b1, 4'd3);

        // wrap and borrow
        rf[1] = 8'hFF; rf[2] = 8'h01; rf[7] = 8'h55;
        exec_op(3'b000, 4'd1, 4'd2, 4'd7, 1'b0);
        expect_op("add_wrap", 8'h00, 1'b1, 1'b1, 1'b1, 4'd7);
        exec_op(3'b001, 4'd2, 4'd1, 4'd8, 1'b0);
        expect_op("sub_borrow", 8'h02, 1'b1, 1'b0, 1'b1, 4'd8);

        // CMP equal: flags only, no write-back
        rf[4] = 8'h2A; rf[5] = 8'h2A; rf[9] = 8'h77;
        exec_op(3'b111, 4'd4, 4'd5, 4'd9, 1'b0);
        expect_op("cmp_eq", 8'h00, 1'b0, 1'b1, 1'b0, 4'd9);
        check("cmp_rf_untouched", rf[9], 8'h77);

        // shifts
        rf[10] = 8'h81;
        exec_op(3'b101, 4'd10, 4'd0, 4'd11, 1'b0);
        expect_op("shl", 8'h02, 1'b1, 1'b0, 1'b1, 4'd11);
        exec_op(3'b110, 4'd10, 4'd0, 4'd12, 1'b0);
        expect_op("shr", 8'h40, 1'b1, 1'b0, 1'b1, 4'd12);

        // logic ops
        rf[13] = 8'hC3; rf[14] = 8'h5A;
        exec_op(3'b010, 4'd13, 4'd14, 4'd2, 1'b0);
        expect_op("and", 8'h42, 1'b0, 1'b0, 1'b1, 4'd2);
        exec_op(3'b011, 4'd13, 4'd14, 4'd2, 1'b0);
        expect_op("or", 8'hDB, 1'b0, 1'b0, 1'b1, 4'd2);
        exec_op(3'b100, 4'd13, 4'd14, 4'd2, 1'b0);
        expect_op("xor", 8'h99, 1'b0, 1'b0, 1'b1, 4'd2);

        // full aliasing plus a start pulse while busy
        rf[6] = 8'h10;
        exec_op(3'b000, 4'd6, 4'd6, 4'd6, 1'b1);
        expect_op("alias", 8'h20, 1'b0, 1'b0, 1'b1, 4'd6);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (busy || wrt_enable) stray++;
        end
        check("busy_start_ignored", stray, 0);
        check("alias_rf6_once", rf[6], 8'h20);

        // reset during EXEC
        rf[1] = 8'h05; rf[2] = 8'h03; rf[15] = 8'h33;
        @(negedge clock);
        op = 3'b000; src_a = 4'd1; src_b = 4'd2; dst = 4'd15; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("mid_state_exec", state_dbg, 2);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 0);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (wrt_enable || done) stray++;
            @(negedge clock);
        end
        check("mid_rst_no_strobes", stray, 0);
        check("mid_rst_rf_unchanged", rf[15], 8'h33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
